// File: rtl/zoom_pkg.sv
// Shared constants, pixel type and window indexing for the ZOOM 3x3 window generator.
package zoom_pkg;
  localparam int ZOOM_ADDR_W = 11;
  localparam int ZOOM_DATA_W = 16;
  localparam int LAT         = 5;
  localparam int WIN_ROWS    = 3;
  localparam int WIN_COLS    = 3;

  typedef logic [ZOOM_DATA_W-1:0] pix_t;

  // Flat slot of (row, col) inside the packed window; row 0 / col 0 are the oldest.
  function automatic int win_idx(input int r, input int c);
    return r * WIN_COLS + c;
  endfunction
endpackage

// File: rtl/zoom_line_ram.sv
// Single-port line buffer: read-before-write, two output register stages (2-cycle read latency).
module zoom_line_ram
  import zoom_pkg::*;
#(
  parameter int ADDR_W = ZOOM_ADDR_W,
  parameter int DATA_W = ZOOM_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] q_p1, q_p2;

  // Non-blocking read of mem returns the old word when the same address is written.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    q_p1 <= mem[addr];
    q_p2 <= q_p1;
  end

  assign rdata = q_p2;

endmodule

// File: rtl/zoom_matrix_3x3.sv
// Raster stream to registered 3x3 pixel window using two line RAMs.
// Optional ZOOM_MATRIX_TOP_REP_EN: replicate the top line(s) so every output line is valid.
module zoom_matrix_3x3
  import zoom_pkg::*;
#(
  parameter int ADDR_W = ZOOM_ADDR_W,
  parameter int DATA_W = ZOOM_DATA_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_vs,
  input  logic                                i_de,
  input  logic [DATA_W-1:0]                   i_data,
  output logic                                o_vs,
  output logic                                o_de,
  output logic                                o_win_valid,
  output logic [WIN_ROWS*WIN_COLS*DATA_W-1:0] o_win
);

  logic [ADDR_W-1:0] col, col_p1, col_p2, col_p3, col_p4;
  logic [1:0]        row, row_p1, row_p2, row_p3, row_p4;
  logic [DATA_W-1:0] data_p1, data_p2, data_p3, data_p4;
  logic [DATA_W-1:0] line1_p3, line1_p4;
  logic [DATA_W-1:0] ram0_q, ram1_q;
  logic [LAT-1:0]    vld_sr, vs_sr;
  logic [DATA_W-1:0] src_p4 [WIN_ROWS];
  logic [DATA_W-1:0] tap_p5 [WIN_ROWS][WIN_COLS];
  logic              win_valid_p5;
  logic              vs_rise, de_fall;

  function automatic logic [1:0] row_sat_inc(input logic [1:0] r);
    return (r == 2'd3) ? r : r + 2'd1;
  endfunction

  assign vs_rise = i_vs && !vs_sr[0];
  assign de_fall = vld_sr[0] && !i_de;

  // p0: position counters for the pixel on the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else begin
      if (i_de) col <= col + 1'b1;
      else      col <= '0;
      if (vs_rise)      row <= '0;
      else if (de_fall) row <= row_sat_inc(row);
    end
  end

  zoom_line_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram0 (
    .clk   (clk),
    .we    (i_de),
    .addr  (col),
    .wdata (i_data),
    .rdata (ram0_q)
  );

  zoom_line_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram1 (
    .clk   (clk),
    .we    (vld_sr[1]),
    .addr  (col_p2),
    .wdata (ram0_q),
    .rdata (ram1_q)
  );

  // p1..p4: delay newest line, position and sync to meet the RAM outputs at p4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr   <= '0;
      vs_sr    <= '0;
      col_p1   <= '0; col_p2  <= '0; col_p3  <= '0; col_p4  <= '0;
      row_p1   <= '0; row_p2  <= '0; row_p3  <= '0; row_p4  <= '0;
      data_p1  <= '0; data_p2 <= '0; data_p3 <= '0; data_p4 <= '0;
      line1_p3 <= '0;
      line1_p4 <= '0;
    end else begin
      vld_sr   <= {vld_sr[LAT-2:0], i_de};
      vs_sr    <= {vs_sr[LAT-2:0], i_vs};
      col_p1   <= col;    col_p2  <= col_p1;  col_p3  <= col_p2;  col_p4  <= col_p3;
      row_p1   <= row;    row_p2  <= row_p1;  row_p3  <= row_p2;  row_p4  <= row_p3;
      data_p1  <= i_data; data_p2 <= data_p1; data_p3 <= data_p2; data_p4 <= data_p3;
      line1_p3 <= ram0_q;
      line1_p4 <= line1_p3;
    end
  end

  // p4: row sources, optionally replicating the newest lines over the missing top lines
  always_comb begin
    src_p4[2] = data_p4;
    src_p4[1] = line1_p4;
    src_p4[0] = ram1_q;
`ifdef ZOOM_MATRIX_TOP_REP_EN
    if (row_p4 == 2'd0) begin
      src_p4[1] = data_p4;
      src_p4[0] = data_p4;
    end else if (row_p4 == 2'd1) begin
      src_p4[0] = line1_p4;
    end
`endif
  end

  // p5: column taps advance only on valid pixels, so gaps in de leave the window intact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < WIN_ROWS; r++)
        for (int c = 0; c < WIN_COLS; c++)
          tap_p5[r][c] <= '0;
      win_valid_p5 <= 1'b0;
    end else begin
      if (vld_sr[LAT-2]) begin
        for (int r = 0; r < WIN_ROWS; r++) begin
          tap_p5[r][0] <= tap_p5[r][1];
          tap_p5[r][1] <= tap_p5[r][2];
          tap_p5[r][2] <= src_p4[r];
        end
      end
`ifdef ZOOM_MATRIX_TOP_REP_EN
      win_valid_p5 <= vld_sr[LAT-2] && (col_p4 >= ADDR_W'(2));
`else
      win_valid_p5 <= vld_sr[LAT-2] && (col_p4 >= ADDR_W'(2)) && (row_p4 >= 2'd2);
`endif
    end
  end

  for (genvar r = 0; r < WIN_ROWS; r++) begin : g_row
    for (genvar c = 0; c < WIN_COLS; c++) begin : g_col
      assign o_win[DATA_W*win_idx(r, c) +: DATA_W] = tap_p5[r][c];
    end
  end

  assign o_win_valid = win_valid_p5;
  assign o_de        = vld_sr[LAT-1];
  assign o_vs        = vs_sr[LAT-1];

endmodule
